// File: rtl/control_unit_pkg.sv
// ---------------------------------------------------------------------------
// control_unit_pkg
//
// Shared opcode definitions for the accumulator datapath. The ALU and the
// control_unit both import this package so the two sides always agree on
// the meaning of every 4-bit opcode.
//
// Contents:
//   OPCODE_WIDTH  width of the opcode field of an instruction word
//   OP_*          opcode constants (codes B..E are unassigned and run as NOP)
//   decode_t      one-hot-ish class flags produced by instr_decoder
// ---------------------------------------------------------------------------
package control_unit_pkg;

   localparam int OPCODE_WIDTH = 4;

   // ALU operations (alu_ce pulses in EXECUTE)
   localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 4'h0;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 4'h1;
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 4'h2;
   localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 4'h3;
   localparam logic [OPCODE_WIDTH-1:0] OP_AND  = 4'h4;
   localparam logic [OPCODE_WIDTH-1:0] OP_OR   = 4'h5;
   localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = 4'h6;
   localparam logic [OPCODE_WIDTH-1:0] OP_NOT  = 4'h7;

   // Sequencer-only operations
   localparam logic [OPCODE_WIDTH-1:0] OP_ST   = 4'h8;
   localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 4'h9;
   localparam logic [OPCODE_WIDTH-1:0] OP_JZ   = 4'hA;
   localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 4'hF;

   // Instruction class flags. At most one of is_alu/is_st/is_jmp/is_jz/is_halt
   // is set for any opcode; is_carry is a qualifier on top of is_alu.
   typedef struct packed {
      logic is_alu;
      logic is_carry;
      logic is_st;
      logic is_jmp;
      logic is_jz;
      logic is_halt;
   } decode_t;

endpackage : control_unit_pkg

// File: rtl/control_unit_if.sv
// ---------------------------------------------------------------------------
// control_unit_if
//
// Bundles every signal between the sequencer and its neighbours (program
// memory, ALU, register file, and the run/halt handshake with the host).
//
// Signals:
//   run       host -> cu   level; start/continue execution
//   pm_addr   cu -> mem    program memory address (= pc)
//   pm_data   mem -> cu    program memory read data, one cycle after pm_addr
//   opcode    cu -> alu    ALU opcode
//   alu_ce    cu -> alu    ALU clock enable pulse
//   cy_ce     cu -> alu    carry-flag enable pulse
//   rf_addr   cu -> rf     register-file address
//   rf_we     cu -> rf     register-file write strobe
//   acc_zero  alu -> cu    accumulator is zero
//   halted    cu -> host   sequencer sits in HALT
//
// Modports:
//   master  the control_unit side
//   slave   the environment side (memory/ALU/register file/host)
// ---------------------------------------------------------------------------
interface control_unit_if
   import control_unit_pkg::*;
#(
   parameter int PC_WIDTH = 8,
   parameter int IW_WIDTH = 12,
   parameter int RF_AW    = 4
);

   logic                    run;
   logic [PC_WIDTH-1:0]     pm_addr;
   logic [IW_WIDTH-1:0]     pm_data;
   logic [OPCODE_WIDTH-1:0] opcode;
   logic                    alu_ce;
   logic                    cy_ce;
   logic [RF_AW-1:0]        rf_addr;
   logic                    rf_we;
   logic                    acc_zero;
   logic                    halted;

   modport master (
      input  run,
      input  pm_data,
      input  acc_zero,
      output pm_addr,
      output opcode,
      output alu_ce,
      output cy_ce,
      output rf_addr,
      output rf_we,
      output halted
   );

   modport slave (
      output run,
      output pm_data,
      output acc_zero,
      input  pm_addr,
      input  opcode,
      input  alu_ce,
      input  cy_ce,
      input  rf_addr,
      input  rf_we,
      input  halted
   );

endinterface : control_unit_if

// File: rtl/control_unit_instr_decoder.sv
// ---------------------------------------------------------------------------
// instr_decoder
//
// Purely combinational classification of an opcode into the handful of
// classes the sequencer cares about. Unassigned codes (B..E) and NOP fall
// through with every flag clear, which makes them behave as "advance pc only".
//
// Ports:
//   op   in   opcode field of the instruction register
//   dec  out  class flags (see control_unit_pkg::decode_t)
// ---------------------------------------------------------------------------
module instr_decoder
   import control_unit_pkg::*;
(
   input  logic [OPCODE_WIDTH-1:0] op,
   output decode_t                 dec
);

   // Only ADD and SUB produce a meaningful carry, so only they open the
   // carry-flag enable; the other ALU ops must leave the flag alone.
   always_comb begin
      dec = '0;
      case (op)
         OP_ADD, OP_SUB: begin
            dec.is_alu   = 1'b1;
            dec.is_carry = 1'b1;
         end
         OP_LD, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
            dec.is_alu = 1'b1;
         end
         OP_ST:   dec.is_st   = 1'b1;
         OP_JMP:  dec.is_jmp  = 1'b1;
         OP_JZ:   dec.is_jz   = 1'b1;
         OP_HALT: dec.is_halt = 1'b1;
         default: dec = '0;
      endcase
   end

endmodule : instr_decoder

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Fetch/decode/execute sequencer in front of the accumulator ALU. Each
// instruction occupies exactly three cycles:
//   FETCH    pm_addr = pc is presented to the synchronous program memory
//   DECODE   the memory word arrives and is captured into ir
//   EXECUTE  enables pulse for one cycle and pc is advanced or redirected
// HALT is terminal until rst_n; IDLE waits for run.
//
// Ports:
//   clk    in   system clock, all state on the rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    master side of control_unit_if (memory, ALU, register file, host)
// ---------------------------------------------------------------------------
module control_unit
   import control_unit_pkg::*;
#(
   parameter int PC_WIDTH = 8,
   parameter int IW_WIDTH = 12,
   parameter int RF_AW    = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   control_unit_if.master bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_HALT
   } state_e;

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [IW_WIDTH-1:0] ir_q, ir_d;

   decode_t             dec;
   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] jump_target;
   logic                alu_ce_c;
   logic                cy_ce_c;
   logic                rf_we_c;

   instr_decoder u_decoder (
      .op  (ir_q[IW_WIDTH-1 -: OPCODE_WIDTH]),
      .dec (dec)
   );

   // Increment wraps naturally at 2^PC_WIDTH; the operand field is the
   // absolute jump target.
   assign pc_inc      = pc_q + PC_WIDTH'(1);
   assign jump_target = PC_WIDTH'(ir_q[7:0]);

   // State, pc and ir registers. Reset is asynchronous so the enables, which
   // are decoded from state_q, collapse immediately even mid-EXECUTE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state and strobe logic. The run input is only sampled in IDLE and
   // at the end of EXECUTE, so an instruction already fetched always
   // completes even if run drops during FETCH or DECODE.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      alu_ce_c = 1'b0;
      cy_ce_c  = 1'b0;
      rf_we_c  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.run) state_d = ST_FETCH;
         end

         ST_FETCH: begin
            state_d = ST_DECODE;
         end

         ST_DECODE: begin
            ir_d    = bus.pm_data;
            state_d = ST_EXECUTE;
         end

         ST_EXECUTE: begin
            alu_ce_c = dec.is_alu;
            cy_ce_c  = dec.is_carry;
            rf_we_c  = dec.is_st;

            if (dec.is_halt) begin
               state_d = ST_HALT;
            end else begin
               if (dec.is_jmp || (dec.is_jz && bus.acc_zero)) begin
                  pc_d = jump_target;
               end else begin
                  pc_d = pc_inc;
               end
               state_d = bus.run ? ST_FETCH : ST_IDLE;
            end
         end

         ST_HALT: begin
            state_d = ST_HALT;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // opcode/rf_addr come straight from ir: ir only changes at the end of
   // DECODE, so they show the current instruction during EXECUTE and keep
   // showing it until the next one is captured.
   assign bus.pm_addr = pc_q;
   assign bus.opcode  = ir_q[IW_WIDTH-1 -: OPCODE_WIDTH];
   assign bus.rf_addr = ir_q[RF_AW-1:0];
   assign bus.alu_ce  = alu_ce_c;
   assign bus.cy_ce   = cy_ce_c;
   assign bus.rf_we   = rf_we_c;
   assign bus.halted  = (state_q == ST_HALT);

endmodule : control_unit

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//
// Drives control_unit from a behavioural program memory and checks every
// instruction against an instruction-level reference model that knows only
// the architectural rules: a 3-cycle FETCH/DECODE/EXECUTE rhythm, which
// opcodes raise which enables, and how pc moves.
// ---------------------------------------------------------------------------
module tb_control_unit;

   logic clk;
   logic rst_n;

   control_unit_if #(.PC_WIDTH(8), .IW_WIDTH(12), .RF_AW(4)) bus ();

   control_unit #(.PC_WIDTH(8), .IW_WIDTH(12), .RF_AW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 10-time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous program memory: data appears one cycle after the address
   logic [11:0] pm [256];
   logic [11:0] pm_rd;

   always @(posedge clk) begin
      pm_rd <= pm[bus.pm_addr];
   end

   assign bus.pm_data = pm_rd;

   int         n_checks;
   int         n_errors;
   logic [7:0] model_pc;

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at t=%0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Hold reset, check the reset values, then release with run high and
   // step into the first FETCH cycle.
   task automatic resetDut();
      @(negedge clk);
      rst_n        = 1'b0;
      bus.run      = 1'b0;
      bus.acc_zero = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_pm_addr", 32'(bus.pm_addr), 32'h0);
      checkOutput("rst_opcode",  32'(bus.opcode),  32'h0);
      checkOutput("rst_rf_addr", 32'(bus.rf_addr), 32'h0);
      checkOutput("rst_enables", 32'({bus.alu_ce, bus.cy_ce, bus.rf_we}), 32'h0);
      checkOutput("rst_halted",  32'(bus.halted),  32'h0);
      model_pc = 8'h00;
      rst_n    = 1'b1;
      bus.run  = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Run one instruction starting at a negedge inside FETCH.
   // az_sel: 0/1 force acc_zero, 2 random. drop_run pulls run low in DECODE.
   // Returns with the DUT in FETCH of the next instruction, or in HALT.
   task automatic applyStimulus(input int az_sel, input bit drop_run);
      logic [11:0] instr;
      logic [3:0]  op;
      logic        az;
      logic        exp_alu;
      logic        exp_cy;
      logic        exp_st;
      logic [7:0]  npc;
      int          idle_cycles;

      instr = pm[model_pc];
      op    = instr[11:8];

      checkOutput("fetch_pm_addr", 32'(bus.pm_addr), 32'(model_pc));
      checkOutput("fetch_enables", 32'({bus.alu_ce, bus.cy_ce, bus.rf_we}), 32'h0);
      @(posedge clk);
      @(negedge clk);

      checkOutput("decode_enables", 32'({bus.alu_ce, bus.cy_ce, bus.rf_we}), 32'h0);
      if (az_sel == 2) az = 1'($urandom_range(0, 1));
      else             az = (az_sel == 1);
      bus.acc_zero = az;
      if (drop_run) bus.run = 1'b0;
      @(posedge clk);
      @(negedge clk);

      exp_alu = (op >= 4'h1) && (op <= 4'h7);
      exp_cy  = (op == 4'h1) || (op == 4'h2);
      exp_st  = (op == 4'h8);
      checkOutput("exec_opcode",  32'(bus.opcode),  32'(op));
      checkOutput("exec_rf_addr", 32'(bus.rf_addr), 32'(instr[3:0]));
      checkOutput("exec_alu_ce",  32'(bus.alu_ce),  32'(exp_alu));
      checkOutput("exec_cy_ce",   32'(bus.cy_ce),   32'(exp_cy));
      checkOutput("exec_rf_we",   32'(bus.rf_we),   32'(exp_st));
      checkOutput("exec_halted",  32'(bus.halted),  32'h0);

      case (op)
         4'h9:    npc = instr[7:0];
         4'hA:    npc = az ? instr[7:0] : model_pc + 8'd1;
         4'hF:    npc = model_pc;
         default: npc = model_pc + 8'd1;
      endcase
      model_pc = npc;
      @(posedge clk);
      @(negedge clk);

      if (op == 4'hF) begin
         for (int i = 0; i < 6; i++) begin
            checkOutput("halt_halted",  32'(bus.halted),  32'h1);
            checkOutput("halt_pm_addr", 32'(bus.pm_addr), 32'(model_pc));
            checkOutput("halt_enables", 32'({bus.alu_ce, bus.cy_ce, bus.rf_we}), 32'h0);
            bus.run      = ~bus.run;
            bus.acc_zero = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
         end
      end else if (drop_run) begin
         idle_cycles = $urandom_range(1, 3);
         for (int i = 0; i < idle_cycles; i++) begin
            checkOutput("idle_pm_addr", 32'(bus.pm_addr), 32'(model_pc));
            checkOutput("idle_enables", 32'({bus.alu_ce, bus.cy_ce, bus.rf_we}), 32'h0);
            checkOutput("idle_halted",  32'(bus.halted),  32'h0);
            @(posedge clk);
            @(negedge clk);
         end
         bus.run = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Take an instruction to its EXECUTE cycle, then pull rst_n low between
   // clock edges and confirm the strobes and pc drop without waiting.
   task automatic resetMidExecute(input logic [11:0] word);
      for (int i = 0; i < 256; i++) pm[i] = 12'h000;
      pm[0] = 12'h905;
      pm[5] = word;
      resetDut();
      applyStimulus(0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("midexec_strobe", 32'({bus.alu_ce, bus.rf_we}),
                  32'({word[11:8] == 4'h1, word[11:8] == 4'h8}));
      checkOutput("midexec_pc", 32'(bus.pm_addr), 32'h05);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_alu_ce",  32'(bus.alu_ce),  32'h0);
      checkOutput("async_rf_we",   32'(bus.rf_we),   32'h0);
      checkOutput("async_pm_addr", 32'(bus.pm_addr), 32'h0);
      checkOutput("async_opcode",  32'(bus.opcode),  32'h0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      model_pc     = 8'h00;
      rst_n        = 1'b0;
      bus.run      = 1'b0;
      bus.acc_zero = 1'b0;

      // Directed program walking through each instruction class, ending with
      // a pc wrap from 0xFF back to 0x00 and a run drop.
      for (int i = 0; i < 256; i++) pm[i] = 12'h000;
      pm[8'h00] = 12'h123;
      pm[8'h01] = 12'h405;
      pm[8'h02] = 12'h807;
      pm[8'h03] = 12'h940;
      pm[8'h40] = 12'hA10;
      pm[8'h10] = 12'hA10;
      pm[8'h11] = 12'h9FF;
      pm[8'hFF] = 12'h0B0;
      resetDut();
      applyStimulus(2, 1'b0);
      applyStimulus(2, 1'b0);
      applyStimulus(2, 1'b0);
      applyStimulus(2, 1'b0);
      applyStimulus(1, 1'b0);
      applyStimulus(0, 1'b0);
      applyStimulus(2, 1'b0);
      applyStimulus(2, 1'b0);
      checkOutput("wrap_pm_addr", 32'(bus.pm_addr), 32'h00);
      applyStimulus(2, 1'b1);
      applyStimulus(2, 1'b0);

      // Random programs without HALT, with occasional run drops
      for (int i = 0; i < 256; i++) begin
         pm[i] = {4'($urandom_range(0, 14)), 8'($urandom_range(0, 255))};
      end
      resetDut();
      for (int n = 0; n < 200; n++) begin
         applyStimulus(2, ($urandom_range(0, 7) == 0));
      end

      // HALT freezes the sequencer until reset
      for (int i = 0; i < 256; i++) pm[i] = 12'h000;
      pm[0] = 12'h31C;
      pm[1] = 12'hF00;
      resetDut();
      applyStimulus(2, 1'b0);
      applyStimulus(2, 1'b0);
      resetDut();
      checkOutput("recover_halted", 32'(bus.halted), 32'h0);

      // Asynchronous reset landing in the middle of EXECUTE
      resetMidExecute(12'h123);
      resetMidExecute(12'h807);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_control_unit
